// File: rtl/ee354_project_move_ctrl.sv
// Snake move controller: move tick generator plus a 2-deep turn queue feeding In_Dirn/SCEN.
// Optional apple speed-up is enabled by defining MOVE_SPEEDUP_EN.
module ee354_project_move_ctrl #(
    parameter int TICK_DIV = 25_000_000,
    parameter int MIN_DIV  = 6_250_000,
    parameter int DIV_STEP = 1_000_000,
    parameter int DIV_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_q_run,
    input  logic             i_btn_u,
    input  logic             i_btn_d,
    input  logic             i_btn_l,
    input  logic             i_btn_r,
    input  logic             i_new_apple,
    output logic             o_speed_clk,
    output logic [1:0]       o_in_dirn,
    output logic             o_scen,
    output logic [DIV_W-1:0] o_cur_div,
    output logic [1:0]       o_q_count
);

    localparam logic [DIV_W-1:0] L_TICK = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] L_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] L_TWO  = DIV_W'(2);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_dirn;
    logic [1:0]       r_q0;
    logic [1:0]       r_q1;
    logic [1:0]       r_qc;

    logic             w_run;
    logic             w_last;
    logic             w_pop;
    logic             w_btn_v;
    logic [1:0]       w_d;
    logic [1:0]       w_ref;
    logic             w_acc;
    logic             w_push;
    logic [1:0]       w_qc_after;
    logic [1:0]       w_qc_next;
    logic [1:0]       w_q0_next;
    logic [1:0]       w_q1_next;

    assign w_run  = i_q_run & ~i_reset;
    assign w_last = w_run && (r_cnt == r_div - L_ONE);
    assign w_pop  = w_run && (r_cnt == r_div - L_TWO) && (r_qc != 2'd0);

    // The popped head is bypassed to the output so SCEN and the new direction coincide.
    assign o_speed_clk = w_last;
    assign o_scen      = w_pop;
    assign o_in_dirn   = w_pop ? r_q0 : r_dirn;
    assign o_q_count   = r_qc;
    assign o_cur_div   = r_div;

    always_comb begin
        w_btn_v = 1'b1;
        w_d     = 2'b00;
        if (i_btn_u)      w_d = 2'b00;
        else if (i_btn_d) w_d = 2'b01;
        else if (i_btn_l) w_d = 2'b10;
        else if (i_btn_r) w_d = 2'b11;
        else              w_btn_v = 1'b0;
    end

    // Reference is the tail after any pop; a pop that empties the queue leaves its own value.
    assign w_ref = (r_qc == 2'd2) ? r_q1 : ((r_qc == 2'd1) ? r_q0 : r_dirn);
    assign w_acc = w_run && w_btn_v && (w_d != w_ref) && ((w_d ^ w_ref) != 2'b01);

    assign w_qc_after = r_qc - {1'b0, w_pop};
    assign w_push     = w_acc && (w_qc_after != 2'd2);
    assign w_qc_next  = w_qc_after + {1'b0, w_push};

    always_comb begin
        w_q0_next = r_q0;
        w_q1_next = r_q1;
        if (w_pop) w_q0_next = r_q1;
        if (w_push) begin
            if (w_qc_after == 2'd0) w_q0_next = w_d;
            else                    w_q1_next = w_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_dirn <= 2'b00;
            r_q0   <= 2'b00;
            r_q1   <= 2'b00;
            r_qc   <= 2'd0;
        end else if (!i_q_run) begin
            r_cnt <= '0;
            r_qc  <= 2'd0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + L_ONE;
            r_q0  <= w_q0_next;
            r_q1  <= w_q1_next;
            r_qc  <= w_qc_next;
            if (w_pop) r_dirn <= r_q0;
        end
    end

`ifdef MOVE_SPEEDUP_EN
    localparam logic [DIV_W-1:0] L_MIN  = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] L_STEP = DIV_W'(DIV_STEP);

    logic             r_apple_q;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] w_pend_next;

    // Pending period tracks apples immediately; Cur_Div only adopts it at a wrap.
    always_comb begin
        w_pend_next = r_pend;
        if (w_run && i_new_apple && !r_apple_q) begin
            if (r_pend - L_MIN >= L_STEP) w_pend_next = r_pend - L_STEP;
            else                          w_pend_next = L_MIN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_apple_q <= 1'b0;
            r_pend    <= L_TICK;
            r_div     <= L_TICK;
        end else begin
            r_apple_q <= i_new_apple;
            r_pend    <= w_pend_next;
            if (w_last) r_div <= w_pend_next;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (MIN_DIV > 0) ^ (DIV_STEP > 0) ^ i_new_apple;
    assign r_div        = L_TICK;
`endif

endmodule

// File: tb/tb_ee354_project_move_ctrl.sv
// Bench for ee354_project_move_ctrl: scripted vector table, speed-up sequence, then random run vs a queue model.
// Build with MOVE_SPEEDUP_EN defined to exercise the speed-up path.
module tb_ee354_project_move_ctrl;

    localparam int TICK = 8;
    localparam int MINP = 4;
    localparam int STEP = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        q_run;
    logic        btn_u, btn_d, btn_l, btn_r;
    logic        new_apple;
    logic        speed_clk;
    logic [1:0]  in_dirn;
    logic        scen;
    logic [31:0] cur_div;
    logic [1:0]  q_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Reference model state
    int         m_cnt;
    int         m_div;
    int         m_pend;
    logic [1:0] m_dirn;
    logic       m_apple_q;
    logic [1:0] m_q[$];

    typedef struct {
        logic       run;
        logic [3:0] btn;   // {U, D, L, R}
        logic       sp;
        logic       sc;
        logic [1:0] dirn;
        logic [1:0] qc;
    } vec_t;
    vec_t tbl[$];

    ee354_project_move_ctrl #(
        .TICK_DIV(TICK),
        .MIN_DIV (MINP),
        .DIV_STEP(STEP),
        .DIV_W   (32)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_q_run    (q_run),
        .i_btn_u    (btn_u),
        .i_btn_d    (btn_d),
        .i_btn_l    (btn_l),
        .i_btn_r    (btn_r),
        .i_new_apple(new_apple),
        .o_speed_clk(speed_clk),
        .o_in_dirn  (in_dirn),
        .o_scen     (scen),
        .o_cur_div  (cur_div),
        .o_q_count  (q_count)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic run, input logic [3:0] btn, input logic sp,
                                input logic sc, input logic [1:0] dirn, input logic [1:0] qc);
        vec_t v;
        v.run = run; v.btn = btn; v.sp = sp; v.sc = sc; v.dirn = dirn; v.qc = qc;
        tbl.push_back(v);
    endfunction

    function automatic void add_idle(input int n, input logic [1:0] dirn, input logic [1:0] qc);
        for (int i = 0; i < n; i++) add(1'b1, 4'b0000, 1'b0, 1'b0, dirn, qc);
    endfunction

    // Driver: apply one cycle of inputs at negedge, compare against the model, then advance the model.
    task automatic step(input logic rst, input logic run, input logic [3:0] b, input logic apple);
        logic       e_sp;
        logic       e_pop;
        logic [1:0] e_dirn;
        logic       bv;
        logic [1:0] d;
        logic [1:0] ref_d;
        @(negedge clk);
        reset = rst; q_run = run;
        {btn_u, btn_d, btn_l, btn_r} = b;
        new_apple = apple;
        #1;
        e_sp   = !rst && run && (m_cnt == m_div - 1);
        e_pop  = !rst && run && (m_cnt == m_div - 2) && (m_q.size() > 0);
        e_dirn = e_pop ? m_q[0] : m_dirn;
        if (chk_en) begin
            chk("model_speed_clk", {31'd0, speed_clk}, {31'd0, e_sp});
            chk("model_scen", {31'd0, scen}, {31'd0, e_pop});
            chk("model_in_dirn", {30'd0, in_dirn}, {30'd0, e_dirn});
            chk("model_q_count", {30'd0, q_count}, m_q.size());
            chk("model_cur_div", cur_div, m_div);
        end
        if (rst) begin
            m_cnt = 0; m_div = TICK; m_pend = TICK; m_dirn = 2'b00; m_apple_q = 1'b0;
            m_q.delete();
        end else if (!run) begin
            m_cnt = 0;
            m_q.delete();
            m_apple_q = apple;
        end else begin
            if (e_pop) m_dirn = m_q.pop_front();
            bv = 1'b1;
            if (b[3])      d = 2'b00;
            else if (b[2]) d = 2'b01;
            else if (b[1]) d = 2'b10;
            else if (b[0]) d = 2'b11;
            else begin bv = 1'b0; d = 2'b00; end
            ref_d = (m_q.size() > 0) ? m_q[$] : m_dirn;
            if (bv && d != ref_d && (d ^ ref_d) != 2'b01 && m_q.size() < 2) m_q.push_back(d);
`ifdef MOVE_SPEEDUP_EN
            if (apple && !m_apple_q) m_pend = (m_pend - STEP < MINP) ? MINP : m_pend - STEP;
            if (e_sp) m_div = m_pend;
`endif
            m_cnt = e_sp ? 0 : m_cnt + 1;
            m_apple_q = apple;
        end
    endtask

    initial begin
        logic [3:0] rb;
        logic       rr;
        reset = 1'b1; q_run = 1'b0; new_apple = 1'b0;
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
        m_cnt = 0; m_div = TICK; m_pend = TICK; m_dirn = 2'b00; m_apple_q = 1'b0;

        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        chk_en = 1;

        // Scripted table: expected values worked out by hand for TICK_DIV=8
        add(1, 4'b0000, 0, 0, 2'b00, 0);
        add(1, 4'b0000, 0, 0, 2'b00, 0);
        add(1, 4'b0001, 0, 0, 2'b00, 0);   // R accepted
        add_idle(3, 2'b00, 1);
        add(1, 4'b0000, 0, 1, 2'b11, 1);   // pre-tick pop
        add(1, 4'b0000, 1, 0, 2'b11, 0);   // tick 8
        add(1, 4'b0010, 0, 0, 2'b11, 0);   // L reversal rejected
        add(1, 4'b0001, 0, 0, 2'b11, 0);   // R duplicate rejected
        add(1, 4'b1000, 0, 0, 2'b11, 0);   // U accepted
        add(1, 4'b0010, 0, 0, 2'b11, 1);   // L accepted vs tail U
        add(1, 4'b0100, 0, 0, 2'b11, 2);   // full: D dropped
        add(1, 4'b1001, 0, 0, 2'b11, 2);   // U+R, full: dropped
        add(1, 4'b0100, 0, 1, 2'b00, 2);   // pop U and push D together
        add(1, 4'b0000, 1, 0, 2'b00, 2);   // tick 16
        add_idle(6, 2'b00, 2);
        add(1, 4'b0000, 0, 1, 2'b10, 2);
        add(1, 4'b0000, 1, 0, 2'b10, 1);   // tick 24
        add_idle(6, 2'b10, 1);
        add(1, 4'b0000, 0, 1, 2'b01, 1);
        add(1, 4'b0000, 1, 0, 2'b01, 0);
        add(1, 4'b1001, 0, 0, 2'b01, 0);   // U wins and is a reversal; R dropped
        add(1, 4'b0110, 0, 0, 2'b01, 0);   // D wins and is a duplicate; L dropped
        add(1, 4'b0011, 0, 0, 2'b01, 0);   // L wins, accepted
        add(1, 4'b1000, 0, 0, 2'b01, 1);   // U accepted
        add(0, 4'b0000, 0, 0, 2'b01, 2);   // q_Run dropped mid-period
        add(0, 4'b0010, 0, 0, 2'b01, 0);   // flushed, press ignored
        add_idle(7, 2'b01, 0);
        add(1, 4'b0000, 1, 0, 2'b01, 0);   // first tick 8 cycles after restart

        for (int i = 0; i < tbl.size(); i++) begin
            step(1'b0, tbl[i].run, tbl[i].btn, 1'b0);
            chk($sformatf("tbl%0d_speed_clk", i), {31'd0, speed_clk}, {31'd0, tbl[i].sp});
            chk($sformatf("tbl%0d_scen", i), {31'd0, scen}, {31'd0, tbl[i].sc});
            chk($sformatf("tbl%0d_in_dirn", i), {30'd0, in_dirn}, {30'd0, tbl[i].dirn});
            chk($sformatf("tbl%0d_q_count", i), {30'd0, q_count}, {30'd0, tbl[i].qc});
        end

        // Apple / period sequence
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b0000, i < 3);
            if (i == 7) chk("div_before_wrap", cur_div, 8);
        end
`ifdef MOVE_SPEEDUP_EN
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 4'b0000, i == 1);
            if (i == 0) chk("div_after_apple1", cur_div, 6);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0000, i == 1);
            if (i == 0) chk("div_after_apple2", cur_div, 4);
        end
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("div_floor", cur_div, 4);
`else
        step(1'b0, 1'b1, 4'b0000, 1'b1);
        chk("div_apple_ignored", cur_div, 8);
`endif
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        step(1'b1, 1'b1, 4'b0000, 1'b0);   // reset mid-period
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        chk("reset_div", cur_div, 8);
        chk("reset_q_count", {30'd0, q_count}, 0);
        chk("reset_in_dirn", {30'd0, in_dirn}, 0);

        // Random phase against the model
        for (int i = 0; i < 2000; i++) begin
            rb = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rr = ($urandom_range(0, 299) == 0);
            step(rr, $urandom_range(0, 24) != 0, rb, $urandom_range(0, 9) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
